// File: rtl/alu_pipe_unit_if.sv
// alu_pipe_unit_if: handshake bundle between an instruction source and
// alu_pipe_unit.
//   in_valid / in_ready / instr          : instruction channel (source -> unit)
//   out_valid / out_ready                : result channel (unit -> consumer)
//   result[WIDTH] / carry / illegal      : registered result and flags
// Modports: master = source/consumer side, slave = alu_pipe_unit side.
interface alu_pipe_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             illegal;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, result, carry, illegal
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, result, carry, illegal
    );
endinterface

// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: decodes a 32-bit instruction word
// (opcode[31:26] imm1[25:18] imm2[17:10] shamt[9:7] funct[5:0]) and executes
// ADD/SUB/SLL/SRL in one cycle, MUL with an iterative shift-add multiplier.
// Undecodable instructions produce result=0, carry=0, illegal=1.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : alu_pipe_unit_if.slave (valid/ready in, valid/ready out,
//            result/carry/illegal)
// Parameters: WIDTH (8..32), MUL_STEPS (must equal WIDTH).
// Optional feature: define ALU_PIPE_ACC_EN to add a persistent accumulator
// with funct ACC (6'b100001) and ACCCLR (6'b100011).
module alu_pipe_unit #(
    parameter int WIDTH     = 8,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic          clk,
    input  logic          resetn,
    alu_pipe_unit_if.slave bus
);
    localparam logic [5:0] OP_ALU = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_MUL = 6'b011000;
`ifdef ALU_PIPE_ACC_EN
    localparam logic [5:0] FN_ACC    = 6'b100001;
    localparam logic [5:0] FN_ACCCLR = 6'b100011;
`endif
    localparam int            CW   = $clog2(MUL_STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

    typedef enum logic [1:0] {IDLE, MULB, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             illegal_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] prod;
    logic [CW-1:0]    cnt;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [2:0]       shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   add_w;
    logic [WIDTH-1:0] dec_res;
    logic             dec_carry;
    logic             dec_ill;
    logic             dec_mul;
    logic [WIDTH-1:0] prod_next;
    logic             accept;

`ifdef ALU_PIPE_ACC_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   acc_sum;
    logic             dec_acc;
    logic             dec_clr;
`endif

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign shamt  = bus.instr[9:7];
    assign a      = WIDTH'(bus.instr[25:18]);
    assign b      = WIDTH'(bus.instr[17:10]);
    assign add_w  = {1'b0, a} + {1'b0, b};
`ifdef ALU_PIPE_ACC_EN
    assign acc_sum = {1'b0, acc} + {1'b0, a};
`endif

    always_comb begin
        dec_res   = '0;
        dec_carry = 1'b0;
        dec_ill   = 1'b0;
        dec_mul   = 1'b0;
`ifdef ALU_PIPE_ACC_EN
        dec_acc   = 1'b0;
        dec_clr   = 1'b0;
`endif
        if (opcode != OP_ALU) begin
            dec_ill = 1'b1;
        end else begin
            case (funct)
                FN_ADD: begin
                    dec_res   = add_w[WIDTH-1:0];
                    dec_carry = add_w[WIDTH];
                end
                FN_SUB: begin
                    dec_res   = a - b;
                    dec_carry = (a < b);
                end
                FN_SLL: dec_res = a << shamt;
                FN_SRL: dec_res = a >> shamt;
                FN_MUL: dec_mul = 1'b1;
`ifdef ALU_PIPE_ACC_EN
                FN_ACC: begin
                    dec_res   = acc_sum[WIDTH-1:0];
                    dec_carry = acc_sum[WIDTH];
                    dec_acc   = 1'b1;
                end
                FN_ACCCLR: dec_clr = 1'b1;
`endif
                default: dec_ill = 1'b1;
            endcase
        end
    end

    // A new instruction may enter from DONE in the same edge that drains
    // the previous result, giving back-to-back issue with no bubble.
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.illegal   = illegal_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Multiplier: LSB of multiplier selects whether the shifted multiplicand
    // is added; bits shifted out past WIDTH are dropped (modulo product).
    assign prod_next = prod + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            result_q  <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (dec_mul) begin
                            state  <= MULB;
                            mcand  <= a;
                            mplier <= b;
                            prod   <= '0;
                            cnt    <= '0;
                        end else begin
                            state     <= DONE;
                            result_q  <= dec_res;
                            carry_q   <= dec_carry;
                            illegal_q <= dec_ill;
                        end
                    end else if ((state == DONE) && bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                MULB: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        result_q  <= prod_next;
                        carry_q   <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_PIPE_ACC_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (accept && dec_acc) begin
            acc <= acc_sum[WIDTH-1:0];
        end else if (accept && dec_clr) begin
            acc <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_alu_pipe_unit.sv
// Testbench for alu_pipe_unit (WIDTH=8): directed vector table, handshake
// corner sequences (backpressure, back-to-back, reset mid-MUL) and random
// instructions checked against a behavioural model.
module tb_alu_pipe_unit;
    localparam int W = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_unit_if #(.WIDTH(W)) bus ();

    alu_pipe_unit #(.WIDTH(W), .MUL_STEPS(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int acc_m  = 0;

    typedef struct {
        logic [31:0] ins;
        logic [7:0]  res;
        logic        c;
        logic        il;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [7:0] i1,
                                       input logic [7:0] i2, input logic [2:0] sh,
                                       input logic [5:0] fn);
        return {op, i1, i2, sh, 1'b0, fn};
    endfunction

    // Returns {illegal, carry, result}; tracks the accumulator in acc_m.
    function automatic logic [9:0] model(input logic [31:0] ins);
        int a, b, sh, s;
        logic [5:0] op, fn;
        logic [7:0] r;
        logic c, il;
        op = ins[31:26];
        fn = ins[5:0];
        a  = int'(ins[25:18]);
        b  = int'(ins[17:10]);
        sh = int'(ins[9:7]);
        r = 8'h00; c = 1'b0; il = 1'b0;
        if (op != 6'd0) begin
            il = 1'b1;
        end else begin
            case (fn)
                6'h20: begin s = a + b; r = 8'(s); c = (s > 255); end
                6'h22: begin r = 8'(a - b); c = (a < b); end
                6'h00: r = 8'(a << sh);
                6'h02: r = 8'(a >> sh);
                6'h18: r = 8'(a * b);
`ifdef ALU_PIPE_ACC_EN
                6'h21: begin s = acc_m + a; c = (s > 255); acc_m = s % 256; r = 8'(acc_m); end
                6'h23: begin acc_m = 0; r = 8'h00; end
`endif
                default: il = 1'b1;
            endcase
        end
        return {il, c, r};
    endfunction

    // Issues one instruction, waits for its result with out_ready low,
    // reports latency (edges from accept, inclusive) and in_ready-low cycles,
    // then drains the result.
    task automatic run_op(input logic [31:0] ins, output logic [7:0] r, output logic c,
                          output logic il, output int lat, output int lowcnt);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.instr    = $urandom;
        lat    = 1;
        lowcnt = 0;
        while (!bus.out_valid && lat < 50) begin
            if (!bus.in_ready) lowcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        r  = bus.result;
        c  = bus.carry;
        il = bus.illegal;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        logic c, il;
        int lat, lowcnt, seen;
        logic [9:0] e;
        logic [31:0] ins;
        logic [5:0] fn;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.instr     = '0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_carry_illegal", {62'd0, bus.carry, bus.illegal}, 64'd0);

        // Directed vectors
        tbl.push_back('{mk(6'h00, 8'h7F, 8'h01, 3'd0, 6'h20), 8'h80, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'hFF, 8'h01, 3'd0, 6'h20), 8'h00, 1'b1, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h00, 8'h01, 3'd0, 6'h22), 8'hFF, 1'b1, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h05, 8'h03, 3'd0, 6'h22), 8'h02, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h81, 8'h00, 3'd3, 6'h00), 8'h08, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h81, 8'h00, 3'd7, 6'h02), 8'h01, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h5A, 8'h00, 3'd0, 6'h00), 8'h5A, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'hA5, 8'h00, 3'd0, 6'h02), 8'hA5, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h0F, 8'h11, 3'd0, 6'h18), 8'hFF, 1'b0, 1'b0, 9});
        tbl.push_back('{mk(6'h00, 8'h10, 8'h10, 3'd0, 6'h18), 8'h00, 1'b0, 1'b0, 9});
        tbl.push_back('{mk(6'h00, 8'h00, 8'h37, 3'd0, 6'h18), 8'h00, 1'b0, 1'b0, 9});
        tbl.push_back('{mk(6'h00, 8'hFF, 8'hFF, 3'd0, 6'h18), 8'h01, 1'b0, 1'b0, 9});
        tbl.push_back('{mk(6'h01, 8'h12, 8'h34, 3'd0, 6'h20), 8'h00, 1'b0, 1'b1, 1});
        tbl.push_back('{mk(6'h00, 8'h12, 8'h34, 3'd0, 6'h3F), 8'h00, 1'b0, 1'b1, 1});
`ifdef ALU_PIPE_ACC_EN
        tbl.push_back('{mk(6'h00, 8'h05, 8'h00, 3'd0, 6'h21), 8'h05, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h05, 8'h00, 3'd0, 6'h21), 8'h0A, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'hF8, 8'h00, 3'd0, 6'h21), 8'h02, 1'b1, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h05, 8'h00, 3'd0, 6'h23), 8'h00, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h07, 8'h00, 3'd0, 6'h21), 8'h07, 1'b0, 1'b0, 1});
        tbl.push_back('{mk(6'h00, 8'h00, 8'h00, 3'd0, 6'h23), 8'h00, 1'b0, 1'b0, 1});
`else
        tbl.push_back('{mk(6'h00, 8'h05, 8'h00, 3'd0, 6'h21), 8'h00, 1'b0, 1'b1, 1});
        tbl.push_back('{mk(6'h00, 8'h05, 8'h00, 3'd0, 6'h23), 8'h00, 1'b0, 1'b1, 1});
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].ins, r, c, il, lat, lowcnt);
            chk($sformatf("vec%0d_result", i), 64'(r), 64'(tbl[i].res));
            chk($sformatf("vec%0d_carry", i), 64'(c), 64'(tbl[i].c));
            chk($sformatf("vec%0d_illegal", i), 64'(il), 64'(tbl[i].il));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            if (tbl[i].lat == 9) chk($sformatf("vec%0d_in_ready_low", i), 64'(lowcnt), 64'd8);
        end

        // Backpressure: ADD result held, pending SUB not accepted until out_ready
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = mk(6'h00, 8'h10, 8'h20, 3'd0, 6'h20);
        @(posedge clk);
        #1;
        bus.instr = mk(6'h00, 8'h09, 8'h04, 3'd0, 6'h22);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_result_held", 64'(bus.result), 64'h30);
            chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_out_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_sub_result", 64'(bus.result), 64'h05);
        chk("b2b_sub_carry", 64'(bus.carry), 64'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset in the 4th MULB cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = mk(6'h00, 8'h0F, 8'h11, 3'd0, 6'h18);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        acc_m  = 0;
        #1;
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_result", 64'(bus.result), 64'd0);
        chk("mrst_flags", {62'd0, bus.carry, bus.illegal}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        bus.out_ready = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        bus.out_ready = 1'b0;
        chk("mrst_no_stale", 64'(seen), 64'd0);

        // Random instructions against the model
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 6))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h00;
                3: fn = 6'h02;
                4: fn = 6'h18;
                5: fn = ($urandom_range(0, 1) == 0) ? 6'h21 : 6'h23;
                default: fn = 6'($urandom);
            endcase
            ins = mk(($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'h00,
                     8'($urandom), 8'($urandom), 3'($urandom), fn);
            e = model(ins);
            run_op(ins, r, c, il, lat, lowcnt);
            chk($sformatf("rnd%0d_result ins=%08h", i, ins), 64'(r), 64'(e[7:0]));
            chk($sformatf("rnd%0d_carry ins=%08h", i, ins), 64'(c), 64'(e[8]));
            chk($sformatf("rnd%0d_illegal ins=%08h", i, ins), 64'(il), 64'(e[9]));
            chk($sformatf("rnd%0d_latency ins=%08h", i, ins), 64'(lat),
                64'((ins[31:26] == 6'h00 && ins[5:0] == 6'h18) ? 9 : 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_pipe_unit.md
Name: alu_pipe_unit

Overview:
- Parametrised successor of the lab decoder+ALU pair. Decodes the 32-bit instruction format (opcode, imm1, imm2, shamt, funct) and executes in a single unit.
- Sequential: valid/ready handshake on input and output, iterative shift-add multiplier, illegal-instruction flag.
- Sits between the instruction source (switches or testbench) and the display or result consumer.

Parameters:
- WIDTH, 8: datapath and result width; legal range 8..32. imm1/imm2 are zero-extended from 8 bits to WIDTH.
- MUL_STEPS, WIDTH: multiplier iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  instr is valid this cycle
- in_ready  out  1  unit can accept instr this cycle
- instr  in  32  instruction word
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  operation result
- carry  out  1  ADD carry-out / SUB borrow; 0 otherwise
- illegal  out  1  undecodable instruction

Behaviour:
- Decode fields:
  - opcode = instr[31:26], imm1 = instr[25:18], imm2 = instr[17:10], shamt = instr[9:7], funct = instr[5:0].
  - OP_ALU = 6'b000000.
  - funct codes: ADD 6'b100000, SUB 6'b100010, SLL 6'b000000, SRL 6'b000010, MUL 6'b011000.
  - Anything else, including any opcode other than OP_ALU, is illegal.
- Operands: A = zext(imm1), B = zext(imm2). All arithmetic is modulo 2^WIDTH.
  - ADD: {carry,result} = A+B.
  - SUB: result = A-B; carry = 1 iff A<B.
  - SLL: result = A<<shamt. SRL: result = A>>shamt (logical).
  - MUL: result = low WIDTH bits of A*B; carry = 0.
  - Illegal: result = 0, carry = 0, illegal = 1.
- Handshake:
  - Transfer occurs on a rising edge where valid&&ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - out_valid = (state==DONE).
  - result/carry/illegal are registered and held stable while out_valid && !out_ready.
- FSM states IDLE, MULB, DONE:
  - IDLE: on accept, non-MUL -> DONE with result registered (latency 1: out_valid high the cycle after accept). MUL -> MULB, load multiplicand/multiplier, clear accumulator, step counter = 0.
  - MULB: one shift-add step per cycle. After MUL_STEPS steps -> DONE. out_valid rises MUL_STEPS+1 cycles after accept. in_ready = 0 throughout.
  - DONE: on out_ready with no in_valid -> IDLE. On out_ready with in_valid -> accept the new instr in the same edge (back-to-back, no bubble), next state per the IDLE rules. Without out_ready -> stay; in_valid is ignored and not accepted.
- Reset (asynchronous, any state, including mid-MUL):
  - state = IDLE; result = 0, carry = 0, illegal = 0, out_valid = 0; counter and accumulator cleared.
  - in_ready = 1 after reset deassertion.
  - An in-flight instruction is discarded and produces no output.
- Boundaries:
  - shamt = 0 returns A unchanged.
  - MUL by 0 still takes the full MUL_STEPS cycles; no early exit.
  - imm bits beyond WIDTH cannot occur because WIDTH >= 8.
  - instr is sampled only at accept; later changes to instr have no effect.

Optional Feature:
- Macro ALU_PIPE_ACC_EN.
- Defined:
  - Adds funct ACC 6'b100001: acc <= acc + A*? no multiply; acc <= acc + A, result = new acc, carry = carry-out of the add, latency 1.
  - Adds funct ACCCLR 6'b100011: acc <= 0, result = 0.
  - acc is a WIDTH-bit register, reset to 0, and persists across instructions.
- Undefined: no acc register; 6'b100001 and 6'b100011 are illegal.

Test Plan (WIDTH=8):
- ADD imm1=0x7F, imm2=0x01 accepted at edge 0, out_ready=1 -> out_valid high one cycle after edge 0; result=0x80, carry=0, illegal=0. ADD 0xFF+0x01 -> result 0x00, carry=1.
- SUB 0x00-0x01 -> result 0xFF, carry=1. SLL A=0x81 shamt=3 -> 0x08. SRL A=0x81 shamt=7 -> 0x01.
- MUL 0x0F×0x11 -> in_ready low for 8 cycles, out_valid high 9 cycles after accept, result=0xFF. MUL 0x10×0x10 -> result 0x00.
- Backpressure: ADD result held with out_ready=0 for 5 cycles while in_valid=1 -> result stable, in_ready=0, no accept. Raise out_ready with a SUB pending -> SUB accepted on the same edge; its result appears on the next cycle.
- Reset mid-MUL: assert resetn=0 asynchronously in the 4th MULB cycle -> outputs 0 immediately, out_valid=0. After release, in_ready=1 and no stale result ever appears.
- Illegal: opcode 6'b000001, or funct 6'b111111 -> illegal=1, result=0, latency 1. With ALU_PIPE_ACC_EN: ACC A=0x05 twice -> results 0x05 then 0x0A; ACCCLR -> 0x00.
